// File: rtl/uart_dut_pkg.sv
// rtl/uart_dut_pkg.sv - opcodes, state encodings and counter widths for the DUT command sequencer
package uart_dut_pkg;

   localparam logic [7:0] OP_WRITE = 8'h01;
   localparam logic [7:0] OP_READ  = 8'h02;
   localparam logic [7:0] OP_STEP  = 8'h03;
   localparam logic [7:0] OP_EVAL  = 8'h04;

   localparam int TMO_W    = 24;
   localparam int STEP_W   = 8;
   localparam int SETTLE_W = 8;

   typedef enum logic [2:0] {
      IDLE,
      ARG,
      SETTLE,
      STEP,
      TX,
      TX_WAIT
   } seq_state_t;

   typedef enum logic [1:0] {
      SCH_IDLE,
      SCH_PEND,
      SCH_RISE,
      SCH_FALL
   } tx_phase_t;

endpackage

// File: rtl/uart_tx_scheduler.sv
// rtl/uart_tx_scheduler.sv - one-byte-in-flight handshake towards the uart transmitter
module uart_tx_scheduler
   import uart_dut_pkg::*;
(
   input  logic       iCE_CLK,
   input  logic       rst,
   input  logic       req,
   input  logic [7:0] req_byte,
   input  logic       is_transmitting,
   output logic       transmit,
   output logic [7:0] tx_byte,
   output logic       done
);

   tx_phase_t phase, phase_next;

   // The byte is only released once the uart is idle; completion needs a full busy rise and fall.
   assign done = (phase == SCH_FALL) && !is_transmitting;

   // Phase register.
   always_ff @(posedge iCE_CLK or posedge rst) begin
      if (rst) phase <= SCH_IDLE;
      else     phase <= phase_next;
   end

   // Next phase: request -> wait uart idle -> wait busy rise -> wait busy fall.
   always_comb begin
      phase_next = phase;
      case (phase)
         SCH_IDLE: if (req)              phase_next = SCH_PEND;
         SCH_PEND: if (!is_transmitting) phase_next = SCH_RISE;
         SCH_RISE: if (is_transmitting)  phase_next = SCH_FALL;
         SCH_FALL: if (!is_transmitting) phase_next = SCH_IDLE;
         default:                        phase_next = SCH_IDLE;
      endcase
   end

   // Latch the response byte on request and emit a single registered load pulse.
   always_ff @(posedge iCE_CLK or posedge rst) begin
      if (rst) begin
         tx_byte  <= 8'h00;
         transmit <= 1'b0;
      end else begin
         transmit <= (phase == SCH_PEND) && !is_transmitting;
         if (phase == SCH_IDLE && req) tx_byte <= req_byte;
      end
   end

endmodule

// File: rtl/uart_dut_sequencer.sv
// rtl/uart_dut_sequencer.sv - host opcode decoder driving, stepping and sampling a DUT
module uart_dut_sequencer
   import uart_dut_pkg::*;
#(
   parameter int         IN_W          = 8,
   parameter int         OUT_W         = 5,
   parameter int         SETTLE_CYCLES = 4,
   parameter int         ARG_TIMEOUT   = 1200000,
   parameter logic [7:0] ACK_BYTE      = 8'hA5,
   parameter logic [7:0] NAK_BYTE      = 8'hEE
) (
   input  logic             iCE_CLK,
   input  logic             rst,
   input  logic             received,
   input  logic [7:0]       rx_byte,
   input  logic             recv_error,
   input  logic             is_transmitting,
   output logic             transmit,
   output logic [7:0]       tx_byte,
   output logic [IN_W-1:0]  dut_in,
   input  logic [OUT_W-1:0] dut_out,
   output logic             dut_step,
   output logic             busy,
   output logic             cmd_err
);

   if (IN_W < 1 || IN_W > 8) begin : g_bad_in_w
      $error("IN_W must be 1..8");
   end
   if (OUT_W < 1 || OUT_W > 8) begin : g_bad_out_w
      $error("OUT_W must be 1..8");
   end
   if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > (1 << SETTLE_W)) begin : g_bad_settle
      $error("SETTLE_CYCLES out of range for the settle counter");
   end
   if (ARG_TIMEOUT < 1 || ARG_TIMEOUT > (1 << TMO_W)) begin : g_bad_tmo
      $error("ARG_TIMEOUT out of range for the timeout counter");
   end

   localparam logic [TMO_W-1:0]    TMO_LAST    = TMO_W'(ARG_TIMEOUT - 1);
   localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYCLES - 1);

   seq_state_t          state, state_next;
   logic [7:0]          op;
   logic [TMO_W-1:0]    tmo_cnt;
   logic [STEP_W-1:0]   step_cnt;
   logic                step_ph;
   logic [SETTLE_W-1:0] settle_cnt;
   logic                tx_req;
   logic [7:0]          tx_req_byte;
   logic                tx_done;

   assign busy = (state != IDLE);

   // State register.
   always_ff @(posedge iCE_CLK or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   // Next state and response scheduling; every path into TX raises tx_req exactly once.
   always_comb begin
      state_next  = state;
      tx_req      = 1'b0;
      tx_req_byte = NAK_BYTE;
      case (state)
         IDLE: begin
            if (received) begin
               case (rx_byte)
                  OP_WRITE, OP_STEP, OP_EVAL: state_next = ARG;
                  OP_READ: begin
                     state_next  = TX;
                     tx_req      = 1'b1;
                     tx_req_byte = 8'(dut_out);
                  end
                  default: begin
                     state_next = TX;
                     tx_req     = 1'b1;
                  end
               endcase
            end
         end
         ARG: begin
            if (recv_error) begin
               state_next = TX;
               tx_req     = 1'b1;
            end else if (received) begin
               case (op)
                  OP_WRITE: begin
                     state_next  = TX;
                     tx_req      = 1'b1;
                     tx_req_byte = ACK_BYTE;
                  end
                  OP_STEP: state_next = STEP;
                  default: state_next = SETTLE;
               endcase
            end else if (tmo_cnt == TMO_LAST) begin
               state_next = TX;
               tx_req     = 1'b1;
            end
         end
         SETTLE: begin
            if (settle_cnt == SETTLE_LAST) begin
               state_next  = TX;
               tx_req      = 1'b1;
               tx_req_byte = 8'(dut_out);
            end
         end
         STEP: begin
            if (step_cnt == '0 && !step_ph) begin
               state_next  = TX;
               tx_req      = 1'b1;
               tx_req_byte = ACK_BYTE;
            end
         end
         TX:      if (transmit) state_next = TX_WAIT;
         TX_WAIT: if (tx_done)  state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Datapath: opcode latch, argument timeout, DUT bus, step pulses, settle count, sticky drop flag.
   always_ff @(posedge iCE_CLK or posedge rst) begin
      if (rst) begin
         op         <= 8'h00;
         tmo_cnt    <= '0;
         step_cnt   <= '0;
         step_ph    <= 1'b0;
         settle_cnt <= '0;
         dut_in     <= '0;
         dut_step   <= 1'b0;
         cmd_err    <= 1'b0;
      end else begin
         dut_step <= 1'b0;
         case (state)
            IDLE: begin
               if (received) begin
                  op      <= rx_byte;
                  tmo_cnt <= '0;
               end
            end
            ARG: begin
               tmo_cnt <= tmo_cnt + 1'b1;
               if (received && !recv_error) begin
                  case (op)
                     OP_WRITE: dut_in <= rx_byte[IN_W-1:0];
                     OP_STEP: begin
                        step_cnt <= rx_byte;
                        step_ph  <= 1'b0;
                     end
                     default: begin
                        dut_in     <= rx_byte[IN_W-1:0];
                        settle_cnt <= '0;
                     end
                  endcase
               end
            end
            SETTLE: settle_cnt <= settle_cnt + 1'b1;
            STEP: begin
               if (step_ph) begin
                  step_ph <= 1'b0;
               end else if (step_cnt != '0) begin
                  dut_step <= 1'b1;
                  step_ph  <= 1'b1;
                  step_cnt <= step_cnt - 1'b1;
               end
            end
            default: ;
         endcase
         if (received && (state == SETTLE || state == STEP || state == TX || state == TX_WAIT))
            cmd_err <= 1'b1;
      end
   end

   uart_tx_scheduler u_tx_sched (
      .iCE_CLK         (iCE_CLK),
      .rst             (rst),
      .req             (tx_req),
      .req_byte        (tx_req_byte),
      .is_transmitting (is_transmitting),
      .transmit        (transmit),
      .tx_byte         (tx_byte),
      .done            (tx_done)
   );

endmodule
